alu_md_unit: RTL
================

ALU_MD_UNIT -- requirements
Module: alu_md_unit

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, meaning operand/result width (legal: 8, 16, 32, 64).
REQ-002 SHALL derive localparam SHW = log2(DATA_WIDTH), meaning the shift-amount width.
REQ-003 SHALL provide port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit, meaning reset; asynchronous, active-low.
REQ-005 SHALL provide port in_valid, input, 1 bit, meaning an operation is offered.
REQ-006 SHALL provide port in_ready, output, 1 bit, meaning the unit can accept an operation.
REQ-007 SHALL provide port op, input, 4 bits, meaning the operation code (REQ-013).
REQ-008 SHALL provide ports a and b, input, DATA_WIDTH bits each, meaning the operands.
REQ-009 SHALL provide port out_valid, output, 1 bit, meaning the result is held and valid.
REQ-010 SHALL provide port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 SHALL provide ports result and result_hi, output, DATA_WIDTH bits each, meaning the primary result and the secondary result (MUL high word, DIVU remainder, otherwise 0).
REQ-012 SHALL provide port flags, output, 4 bits {N,Z,C,V}, meaning the result flags; port div_by_zero, output, 1 bit, meaning DIVU had b==0.

Function
REQ-013 SHALL decode op as: 0 NOP=0; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XNOR; 6 LSL1; 7 LSR1; 8 LSL b[SHW-1:0]; 9 LSR b[SHW-1:0]; A SLT signed; B ASR1; C ASR b[SHW-1:0]; D SLTU; E MULU (unsigned, 2*DATA_WIDTH product, low word to result, high word to result_hi); F DIVU (quotient to result, remainder to result_hi).
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-015 SHALL drive in_ready=1 only in IDLE; an operation is accepted when in_valid && in_ready at a clock edge; a, b and op are captured at acceptance.
REQ-016 SHALL move single-cycle ops (0-D) IDLE->DONE at acceptance, giving out_valid on the edge after acceptance (latency 1).
REQ-017 SHALL make MULU an iterative shift-add, IDLE->MUL, one multiplier bit per cycle, DATA_WIDTH iterations, then MUL->DONE; out_valid is asserted exactly DATA_WIDTH+1 edges after acceptance.
REQ-018 SHALL make DIVU a restoring division, IDLE->DIV, DATA_WIDTH iterations, DIV->DONE; the latency is identical to MULU.
REQ-019 SHALL, for DIVU with b==0, skip iteration (IDLE->DONE, latency 1) and return result=all ones, result_hi=a, div_by_zero=1; otherwise div_by_zero=0.
REQ-020 SHALL hold result, result_hi, flags and div_by_zero stable in DONE with out_valid=1 until out_ready=1; DONE->IDLE on that edge; out_valid=0 outside DONE.
REQ-021 SHALL ignore in_valid while not IDLE; op, a and b changes mid-iteration do not affect the result.
REQ-022 SHALL compute flags from result: N=result[MSB]; Z=(result==0).
REQ-023 SHALL set C as follows: ADD carry-out; SUB no-borrow (a>=b unsigned); MULU (result_hi!=0); all other ops 0.
REQ-024 SHALL set V to signed overflow for ADD (operands same sign, result sign differs) and SUB (operands differ in sign, result sign differs from a); 0 for all other ops.
REQ-025 SHALL compute all arithmetic modulo 2^DATA_WIDTH, except the MULU product, which is kept at 2*DATA_WIDTH bits internally.

Reset
REQ-026 SHALL, on rst_n low, immediately force IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, flags=0, div_by_zero=0, and clear the iteration counter and datapath registers, including mid-MUL/DIV and in DONE; an interrupted operation is discarded.
REQ-027 SHALL accept no operation while rst_n is low; the first acceptance is possible on the first edge with rst_n high.

Verification (DATA_WIDTH=32)
REQ-028 SHALL verify ADD a=0x7FFFFFFF, b=1 -> 1 cycle later out_valid=1, result=0x80000000, flags N=1 Z=0 C=0 V=1; SUB a=5, b=5 -> result=0, Z=1, C=1.
REQ-029 SHALL verify MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid exactly 33 edges after acceptance, result=0x00000001, result_hi=0xFFFFFFFE, C=1; in_ready=0 throughout.
REQ-030 SHALL verify DIVU a=100, b=7 -> 33 edges, result=14, result_hi=2; DIVU a=9, b=0 -> 1 edge, result=0xFFFFFFFF, result_hi=9, div_by_zero=1.
REQ-031 SHALL verify back-pressure: out_ready=0 for 5 cycles after a DONE with ASR b=4, a=0x80000000 -> result stays 0xF8000000, in_ready=0 and new in_valid ignored; out_ready=1 -> IDLE the next edge.
REQ-032 SHALL verify reset at iteration 10 of MULU -> out_valid=0, result=0, in_ready=1 immediately; a subsequent SLTU a=1, b=2 -> result=1.
REQ-033 SHALL verify a DATA_WIDTH=8 instance: MULU a=0xFF, b=0x02 -> 9 edges, result=0xFE, result_hi=0x01.

Source files
------------

// File: rtl/alu_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_unit
// Description : Valid/ready ALU with single-cycle logic/arith/shift ops, an
//               iterative shift-add unsigned multiplier and an iterative
//               restoring unsigned divider. Results held until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic [3:0]            flags,
  output logic                  div_by_zero
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;
  // DATA_WIDTH is a power of two, so the last iteration index is all ones
  localparam logic [SHW-1:0] LAST_ITER = {SHW{1'b1}};

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XNOR = 4'h5;
  localparam logic [3:0] OP_LSL1 = 4'h6;
  localparam logic [3:0] OP_LSR1 = 4'h7;
  localparam logic [3:0] OP_LSL  = 4'h8;
  localparam logic [3:0] OP_LSR  = 4'h9;
  localparam logic [3:0] OP_SLT  = 4'hA;
  localparam logic [3:0] OP_ASR1 = 4'hB;
  localparam logic [3:0] OP_ASR  = 4'hC;
  localparam logic [3:0] OP_SLTU = 4'hD;
  localparam logic [3:0] OP_MULU = 4'hE;
  localparam logic [3:0] OP_DIVU = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [SHW-1:0]        cnt_q;
  // Multiplicand during MULU, divisor during DIVU
  logic [DATA_WIDTH-1:0] opnd_q;
  // {hi_q, lo_q}: running product (MULU) or remainder/quotient pair (DIVU)
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] result_hi_q;
  logic [3:0]            flags_q;
  logic                  dbz_q;

  // Single-cycle datapath signals, driven from the live inputs at acceptance
  logic [DATA_WIDTH:0]   add_full;
  logic [DATA_WIDTH:0]   sub_full;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;
  logic                  alu_v;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];

  // Multiplier step: add multiplicand when the current multiplier bit is set,
  // then shift the whole {hi,lo} pair right by one (carry enters hi's MSB)
  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH-1:0] mul_hi;
  logic [DATA_WIDTH-1:0] mul_lo;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi  = mul_sum[DATA_WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_q[MSB:1]};

  // Divider step: shift next dividend bit into the partial remainder and
  // subtract the divisor only if it fits (restoring by selection)
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH:0]   div_diff;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] div_rem;
  logic [DATA_WIDTH-1:0] div_quo;

  assign div_shift = {hi_q, lo_q[MSB]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_rem   = div_ge ? div_diff[MSB:0] : div_shift[MSB:0];
  assign div_quo   = {lo_q[MSB-1:0], div_ge};

  function automatic logic [3:0] mk_flags(input logic [DATA_WIDTH-1:0] r,
                                          input logic c, input logic v);
    return {r[MSB], (r == '0), c, v};
  endfunction

  // Single-cycle operation results and carry/overflow
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_NOP:  alu_res = '0;
      OP_ADD: begin
        alu_res = add_full[MSB:0];
        alu_c   = add_full[DATA_WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_full[MSB:0];
        alu_c   = ~sub_full[DATA_WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XNOR: alu_res = ~(a ^ b);
      OP_LSL1: alu_res = {a[MSB-1:0], 1'b0};
      OP_LSR1: alu_res = {1'b0, a[MSB:1]};
      OP_LSL:  alu_res = a << shamt;
      OP_LSR:  alu_res = a >> shamt;
      OP_SLT:  alu_res = {{MSB{1'b0}}, ($signed(a) < $signed(b))};
      OP_ASR1: alu_res = {a[MSB], a[MSB:1]};
      OP_ASR:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLTU: alu_res = {{MSB{1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // Control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            cnt_q <= '0;
            if (op == OP_MULU) begin
              opnd_q  <= a;
              hi_q    <= '0;
              lo_q    <= b;
              state_q <= S_MUL;
            end else if (op == OP_DIVU && b != '0) begin
              opnd_q  <= b;
              hi_q    <= '0;
              lo_q    <= a;
              state_q <= S_DIV;
            end else if (op == OP_DIVU) begin
              result_q    <= {DATA_WIDTH{1'b1}};
              result_hi_q <= a;
              flags_q     <= mk_flags({DATA_WIDTH{1'b1}}, 1'b0, 1'b0);
              dbz_q       <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              result_q    <= alu_res;
              result_hi_q <= '0;
              flags_q     <= mk_flags(alu_res, alu_c, alu_v);
              dbz_q       <= 1'b0;
              state_q     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          hi_q  <= mul_hi;
          lo_q  <= mul_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            result_q    <= mul_lo;
            result_hi_q <= mul_hi;
            flags_q     <= mk_flags(mul_lo, (mul_hi != '0), 1'b0);
            dbz_q       <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DIV: begin
          hi_q  <= div_rem;
          lo_q  <= div_quo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            result_q    <= div_quo;
            result_hi_q <= div_rem;
            flags_q     <= mk_flags(div_quo, 1'b0, 1'b0);
            dbz_q       <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign flags       = flags_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
